mux_serializer: RTL and testbench

MUX_SERIALIZER -- requirements
Module: mux_serializer

---
 rtl/mux_serializer_pkg.sv | 10 +
 rtl/mux_serializer_if.sv | 26 ++
 rtl/mux_serializer_mux.sv | 11 +
 rtl/mux_serializer.sv | 68 ++++++
 tb/tb_mux_serializer.sv | 148 ++++++++++++++
 5 files changed

// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the word-to-bit serializer: default geometry and FSM state codes.
package mux_serializer_pkg;

    localparam int WIDTH_DEF    = 32;
    localparam int CHANNELS_DEF = 5;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/mux_serializer_if.sv
// Parallel-in / serial-out handshake bundle; slave side is the serializer.
interface mux_serializer_if
    import mux_serializer_pkg::*;
#(
    parameter int width    = WIDTH_DEF,
    parameter int channels = CHANNELS_DEF
);
    logic [width-1:0]    in_data;
    logic                in_valid;
    logic                in_ready;
    logic                out_bit;
    logic                out_valid;
    logic                out_ready;
    logic                out_last;
    logic [channels-1:0] sel;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_bit, out_valid, out_last, sel
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_bit, out_valid, out_last, sel
    );
endinterface

// File: rtl/mux_serializer_mux.sv
// Plain N:1 bit mux; picks data_i[sel_i].
module mux_serializer_mux #(
    parameter int width    = 32,
    parameter int channels = 5
) (
    input  logic [width-1:0]    data_i,
    input  logic [channels-1:0] sel_i,
    output logic                bit_o
);
    assign bit_o = data_i[sel_i];
endmodule

// File: rtl/mux_serializer.sv
// Serializes a latched word LSB first; a new word can be taken on the last-bit
// consume so back-to-back words stream without a bubble.
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int width    = WIDTH_DEF,
    parameter int channels = CHANNELS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    mux_serializer_if.slave  bus
);
    localparam logic [channels-1:0] SEL_LAST = channels'(width - 1);

    logic [0:0]          state_q, state_d;
    logic [channels-1:0] sel_q, sel_d;
    logic [width-1:0]    word_q, word_d;
    logic                mux_bit;
    logic                shifting, last, accept, consume;

    mux_serializer_mux #(.width(width), .channels(channels)) u_mux (
        .data_i (word_q),
        .sel_i  (sel_q),
        .bit_o  (mux_bit)
    );

    assign shifting = (state_q == ST_SHIFT);
    assign last     = shifting && (sel_q == SEL_LAST);
    assign consume  = shifting && bus.out_ready;
    assign accept   = bus.in_valid && bus.in_ready;

    assign bus.out_valid = shifting;
    assign bus.out_last  = last;
    // Gated so a stale word left in the latch never shows while idle.
    assign bus.out_bit   = shifting & mux_bit;
    assign bus.in_ready  = !shifting || (last && bus.out_ready);
    assign bus.sel       = sel_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        word_d  = word_q;
        if (accept) begin
            word_d  = bus.in_data;
            sel_d   = '0;
            state_d = ST_SHIFT;
        end else if (consume) begin
            if (last) begin
                sel_d   = '0;
                state_d = ST_IDLE;
            end else begin
                sel_d = sel_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            word_q  <= word_d;
        end
    end
endmodule

// File: tb/tb_mux_serializer.sv
// Directed bench for mux_serializer: reset, streaming, back-to-back, stall, reset mid-word, random backpressure.
module tb_mux_serializer;
    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    mux_serializer_if #(.width(32), .channels(5)) bus ();

    mux_serializer #(.width(32), .channels(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // {valid, last, bit, sel}
    function automatic logic [7:0] obs();
        return {bus.out_valid, bus.out_last, bus.out_bit, bus.sel};
    endfunction

    task automatic accept(input logic [31:0] w);
        bus.in_data  = w;
        bus.in_valid = 1'b1;
        #1;
        chk("accept_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_last"},  64'(bus.out_last),  64'd0);
        chk({tag, "_bit"},   64'(bus.out_bit),   64'd0);
        chk({tag, "_ready"}, 64'(bus.in_ready),  64'd1);
        chk({tag, "_sel"},   64'(bus.sel),       64'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] got;
        int          cnt;
        int          cyc;

        rst           = 1'b1;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        idle_chk("reset");

        // Full word with free-running consumer
        w = 32'hA5A5_0F0F;
        bus.out_ready = 1'b1;
        accept(w);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("a5_bit%0d", i), 64'(obs()),
                64'({1'b1, (i == 31), w[i], 5'(i)}));
            step();
        end
        chk("a5_idle_valid", 64'(bus.out_valid), 64'd0);
        chk("a5_idle_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back words, no bubble
        bus.in_data  = 32'hFFFF_FFFF;
        bus.in_valid = 1'b1;
        step();
        bus.in_data = 32'h0000_0000;
        for (int i = 0; i < 64; i++) begin
            chk($sformatf("b2b_%0d", i), 64'({bus.out_valid, bus.out_bit}),
                64'({1'b1, (i < 32)}));
            if (i == 31) chk("b2b_ready_last", 64'(bus.in_ready), 64'd1);
            if (i == 30) chk("b2b_ready_mid", 64'(bus.in_ready), 64'd0);
            step();
            if (i == 31) bus.in_valid = 1'b0;
        end
        chk("b2b_idle", 64'(bus.out_valid), 64'd0);

        // Stall at sel=0
        bus.out_ready = 1'b0;
        accept(32'h0000_0001);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall_%0d", i), 64'(obs()), 64'({3'b101, 5'd0}));
            step();
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("stall_rel%0d", i), 64'(obs()),
                64'({1'b1, (i == 31), (i == 0), 5'(i)}));
            step();
        end

        // Reset mid-word, with in_valid and out_ready asserted alongside
        w = 32'hDEAD_BEEF;
        accept(w);
        for (int i = 0; i < 10; i++) step();
        chk("rst_pre", 64'(obs()), 64'({1'b1, 1'b0, w[10], 5'd10}));
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        idle_chk("rst_mid");
        step();
        chk("rst_mid_nopartial", 64'(bus.out_valid), 64'd0);

        // Random word, random backpressure, in_data scrambled during SHIFT
        w = $urandom;
        accept(w);
        got = '0;
        cnt = 0;
        cyc = 0;
        while (cnt < 32 && cyc < 1000) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_data   = $urandom;
            #1;
            if (bus.out_valid && bus.out_ready) begin
                got[cnt] = bus.out_bit;
                cnt++;
            end
            step();
            cyc++;
        end
        chk("rand_count", 64'(cnt), 64'd32);
        chk("rand_stream", 64'(got), 64'(w));
        bus.out_ready = 1'b0;
        chk("rand_idle", 64'(bus.out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
